// File: rtl/flash_stream_pkg.sv
// Shared types for the flash stream reader: FSM states and playback direction.
package flash_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; rdata updates the cycle after a pop.
// Pushes while full and pops while empty are dropped; flush empties it in one cycle.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     sample_clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rdata  <= mem[rd_ptr];
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; only the pointers define valid content.
    always_ff @(posedge sample_clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/flash_stream_reader.sv
// Streams words from an Avalon-MM flash port over a wrapping address window into a prefetch FIFO.
// Reads are credit-limited by FIFO space and outstanding count; sample_req pops with 1-cycle latency.
module flash_stream_reader
    import flash_stream_pkg::*;
#(
    parameter int ADDR_W          = 23,
    parameter int DATA_W          = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              sample_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              direction,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic              flash_mem_read,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    input  logic              sample_req,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    output logic              underrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_step;
    logic              read_q;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  out_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_empty;
    logic              fifo_full;
    logic              accept;
    logic              stalled;
    logic              ret;
    logic              push;
    logic              pop;
    logic              flush;
    logic              credit_ok;

    assign accept  = read_q && !flash_mem_waitrequest;
    assign stalled = read_q && flash_mem_waitrequest;
    // Returns are only honoured against a live credit, so stale data after a reset is dropped.
    assign ret     = flash_mem_readdatavalid && (state != IDLE) && (outstanding != '0);
    assign push    = ret && (state == RUN) && !fifo_full;
    assign out_nxt = outstanding + OUT_W'(accept) - OUT_W'(ret);
    assign flush   = (state == DRAIN) && (out_nxt == '0) && !stalled;
    assign pop     = sample_req && !fifo_empty && !flush;
    assign cnt_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

    assign credit_ok = ((SUM_W'(cnt_nxt) + SUM_W'(out_nxt)) < SUM_W'(FIFO_DEPTH))
                    && (out_nxt < OUT_W'(MAX_OUTSTANDING));

    always_comb begin
        addr_step = addr_q;
        if (direction == DIR_FWD) begin
            addr_step = (addr_q == end_addr) ? start_addr : addr_q + 1'b1;
        end else begin
            addr_step = (addr_q == start_addr) ? end_addr : addr_q - 1'b1;
        end
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            read_q       <= 1'b0;
            outstanding  <= '0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= pop;
            underrun     <= sample_req && !pop;
            case (state)
                IDLE: begin
                    outstanding <= '0;
                    if (start && !stop) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        addr_q <= (direction == DIR_REV) ? end_addr : start_addr;
                        read_q <= 1'b1;
                    end
                end
                RUN: begin
                    outstanding <= out_nxt;
                    if (accept) addr_q <= addr_step;
                    if (stop) begin
                        state  <= DRAIN;
                        read_q <= stalled;
                    end else if (!stalled) begin
                        read_q <= credit_ok;
                    end
                end
                DRAIN: begin
                    outstanding <= out_nxt;
                    if (accept) addr_q <= addr_step;
                    read_q <= stalled;
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    read_q <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_prefetch (
        .sample_clk (sample_clk),
        .reset      (reset),
        .push       (push),
        .wdata      (flash_mem_readdata),
        .pop        (pop),
        .flush      (flush),
        .rdata      (fifo_rdata),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign flash_mem_read    = read_q;
    assign flash_mem_address = addr_q;
    assign sample_data       = fifo_rdata;

endmodule

// File: tb/tb_flash_stream_reader.sv
// Directed bench for flash_stream_reader with a latency-programmable Avalon read model.
module tb_flash_stream_reader;

    logic        sample_clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        direction = 1'b0;
    logic [22:0] start_addr = 23'h10;
    logic [22:0] end_addr = 23'h12;
    logic [22:0] flash_mem_address;
    logic        flash_mem_read;
    logic        flash_mem_waitrequest = 1'b0;
    logic        flash_mem_readdatavalid = 1'b0;
    logic [31:0] flash_mem_readdata = '0;
    logic        sample_req = 1'b0;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        underrun;
    logic        busy;

    int n_vec = 0;
    int n_miss = 0;
    int mem_lat = 1;
    int cyc = 0;
    int rdv_cnt = 0;
    int rdv_base;
    int stall_cnt;
    logic [31:0] prev_data;
    logic [22:0] acc_log[$];
    int          due_q[$];
    logic [31:0] dat_q[$];

    flash_stream_reader dut (
        .sample_clk              (sample_clk),
        .reset                   (reset),
        .start                   (start),
        .stop                    (stop),
        .direction               (direction),
        .start_addr              (start_addr),
        .end_addr                (end_addr),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .flash_mem_readdata      (flash_mem_readdata),
        .sample_req              (sample_req),
        .sample_data             (sample_data),
        .sample_valid            (sample_valid),
        .underrun                (underrun),
        .busy                    (busy)
    );

    initial forever #5 sample_clk = ~sample_clk;

    function automatic logic [31:0] word_of(input logic [22:0] a);
        return 32'hA500_0000 | {9'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sample_clk);
    endtask

    // Each window sits before one rising edge: drive return data due now, log an acceptance.
    initial begin
        forever begin
            @(negedge sample_clk);
            #2;
            cyc++;
            flash_mem_readdatavalid = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata = dat_q.pop_front();
                void'(due_q.pop_front());
                rdv_cnt++;
            end
            if (flash_mem_read && !flash_mem_waitrequest) begin
                acc_log.push_back(flash_mem_address);
                due_q.push_back(cyc + mem_lat);
                dat_q.push_back(word_of(flash_mem_address));
            end
        end
    end

    task automatic reset_chk(input string tag);
        chk({tag, "_read"}, flash_mem_read, 0);
        chk({tag, "_addr"}, flash_mem_address, 0);
        chk({tag, "_data"}, sample_data, 0);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic start_stream(input logic dir);
        direction = dir;
        acc_log.delete();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        sample_req = 1'b1;
        tick(1);
        sample_req = 1'b0;
        chk({tag, "_valid"}, sample_valid, 1);
        chk(tag, sample_data, exp);
    endtask

    task automatic stop_and_drain(input string tag);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        for (int i = 0; i < 40 && busy; i++) tick(1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        tick(3);
        reset_chk("rst");
        reset = 1'b0;
        tick(2);

        // Forward window with an underrun on the first cycle after start.
        start_stream(1'b0);
        chk("fwd_first_read", flash_mem_read, 1);
        chk("fwd_first_addr", flash_mem_address, 23'h10);
        sample_req = 1'b1;
        tick(1);
        sample_req = 1'b0;
        chk("udr_pulse", underrun, 1);
        chk("udr_valid", sample_valid, 0);
        chk("udr_data", sample_data, 0);
        tick(1);
        chk("udr_one_cycle", underrun, 0);
        tick(18);
        chk("fwd_nacc", acc_log.size(), 4);
        chk("fwd_acc0", acc_log[0], 23'h10);
        chk("fwd_acc1", acc_log[1], 23'h11);
        chk("fwd_acc2", acc_log[2], 23'h12);
        chk("fwd_acc3", acc_log[3], 23'h10);
        chk("fwd_full_noread", flash_mem_read, 0);
        chk("fwd_busy", busy, 1);
        pop_chk("fwd_pop0", word_of(23'h10));
        pop_chk("fwd_pop1", word_of(23'h11));
        pop_chk("fwd_pop2", word_of(23'h12));
        pop_chk("fwd_pop3", word_of(23'h10));
        tick(5);
        pop_chk("fwd_pop4", word_of(23'h11));
        stop_and_drain("fwd");

        // Reverse window; the previous stream's leftovers must have been flushed.
        start_stream(1'b1);
        chk("rev_first_addr", flash_mem_address, 23'h12);
        tick(20);
        chk("rev_nacc", acc_log.size(), 4);
        chk("rev_acc0", acc_log[0], 23'h12);
        chk("rev_acc1", acc_log[1], 23'h11);
        chk("rev_acc2", acc_log[2], 23'h10);
        chk("rev_acc3", acc_log[3], 23'h12);
        pop_chk("rev_pop0", word_of(23'h12));
        pop_chk("rev_pop1", word_of(23'h11));
        pop_chk("rev_pop2", word_of(23'h10));
        pop_chk("rev_pop3", word_of(23'h12));
        stop_and_drain("rev");

        // Three-cycle waitrequest stall on address 0x11.
        start_stream(1'b0);
        stall_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (stall_cnt > 0 && stall_cnt < 4) begin
                chk("stall_read", flash_mem_read, 1);
                chk("stall_addr", flash_mem_address, 23'h11);
            end
            if (flash_mem_read && flash_mem_address == 23'h11 && stall_cnt < 3) begin
                flash_mem_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                flash_mem_waitrequest = 1'b0;
                if (stall_cnt == 3) stall_cnt = 4;
            end
            tick(1);
        end
        flash_mem_waitrequest = 1'b0;
        chk("stall_cycles", stall_cnt, 4);
        chk("stall_nacc", acc_log.size(), 4);
        chk("stall_acc0", acc_log[0], 23'h10);
        chk("stall_acc1", acc_log[1], 23'h11);
        chk("stall_acc2", acc_log[2], 23'h12);
        chk("stall_acc3", acc_log[3], 23'h10);
        stop_and_drain("stall");

        // Stop with two reads in flight on a slow memory.
        mem_lat = 5;
        prev_data = sample_data;
        rdv_base = rdv_cnt;
        start_stream(1'b0);
        tick(1);
        chk("stop_second_read", flash_mem_read, 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_read_off", flash_mem_read, 0);
        chk("stop_busy", busy, 1);
        for (int i = 0; i < 30 && busy; i++) begin
            if (sample_valid) chk("stop_no_valid", sample_valid, 0);
            tick(1);
        end
        chk("stop_idle", busy, 0);
        chk("stop_returns", rdv_cnt - rdv_base, 2);
        chk("stop_data_held", sample_data, prev_data);
        mem_lat = 1;
        start_stream(1'b0);
        sample_req = 1'b1;
        tick(1);
        sample_req = 1'b0;
        chk("stop_fifo_empty", underrun, 1);
        stop_and_drain("stop2");

        // Reset in the middle of a run with reads outstanding.
        mem_lat = 5;
        start_stream(1'b0);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset_chk("mid_rst");
        reset = 1'b0;
        tick(8);
        chk("mid_rst_busy", busy, 0);
        mem_lat = 1;
        start_stream(1'b0);
        chk("restart_read", flash_mem_read, 1);
        chk("restart_addr", flash_mem_address, 23'h10);
        sample_req = 1'b1;
        tick(1);
        sample_req = 1'b0;
        chk("restart_underrun", underrun, 1);
        chk("restart_valid", sample_valid, 0);
        tick(5);
        chk("restart_acc0", acc_log[0], 23'h10);
        stop_and_drain("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/flash_stream_reader.md
Name: flash_stream_reader

Overview:
- Parametrised successor to the single-word flash reader.
- Streams 32-bit audio words from the Avalon-MM flash port into a prefetch FIFO, with pipelined (multi-outstanding) reads.
- Generates its own addresses over a programmable window and plays it in forward or reverse, with wrap-around at the window edges.
- Sits between the flash controller and the audio sample path; the sample path pulls one word per sample_req.

Parameters:
- ADDR_W, 23, flash word-address width.
- DATA_W, 32, flash data width.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- MAX_OUTSTANDING, 2, maximum issued-but-unreturned reads; must be ≤ FIFO_DEPTH.

Ports:
- sample_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begin streaming (acted on only in IDLE).
- stop  in  1  pulse; stop streaming.
- direction  in  1  0 = forward, 1 = reverse; sampled at each address step.
- start_addr  in  ADDR_W  window low bound, inclusive.
- end_addr  in  ADDR_W  window high bound, inclusive; requirement: end_addr ≥ start_addr.
- flash_mem_address  out  ADDR_W  read address.
- flash_mem_read  out  1  Avalon read request.
- flash_mem_waitrequest  in  1  Avalon stall.
- flash_mem_readdatavalid  in  1  read data valid.
- flash_mem_readdata  in  DATA_W  read data.
- sample_req  in  1  consumer pulse; pop one word.
- sample_data  out  DATA_W  popped word, registered.
- sample_valid  out  1  one-cycle pulse, sample_data updated.
- underrun  out  1  one-cycle pulse, sample_req arrived with the FIFO empty.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset values: flash_mem_read=0, flash_mem_address=0, sample_data=0, sample_valid=0, underrun=0, busy=0. FIFO is emptied, outstanding count is 0, state is IDLE. Reset mid-burst abandons in-flight reads; readdatavalid is ignored until the next start.
- States: IDLE, RUN, DRAIN.

IDLE:
- start → RUN. The address register loads start_addr if direction=0, or end_addr if direction=1.
- Loading happens on the start cycle; the first read is asserted the following cycle.

RUN: issue rule
- Assert flash_mem_read when (fifo_count + outstanding) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
- A read is accepted in any cycle with flash_mem_read=1 and waitrequest=0.
- While waitrequest=1, flash_mem_read and flash_mem_address are held stable.

RUN: on acceptance
- outstanding increments.
- The address steps.
  - Forward: +1, or wraps to start_addr when the address equals end_addr.
  - Reverse: −1, or wraps to end_addr when the address equals start_addr.
- If start_addr == end_addr, the address stays constant.

RUN: data return and consumer side
- On readdatavalid: push readdata into the FIFO and decrement outstanding.
  - Acceptance and return in the same cycle leave outstanding unchanged.
  - The credit rule guarantees the FIFO never overflows.
- On sample_req with the FIFO non-empty: pop the head word. sample_data takes it next cycle and sample_valid pulses that same cycle (1-cycle latency).
- On sample_req with the FIFO empty: underrun pulses next cycle, sample_data holds its value and sample_valid stays 0.
- Push and pop in the same cycle are both honoured; the count is unchanged.

Stop:
- stop in RUN → DRAIN, and flash_mem_read deasserts next cycle.
- Exception: a read currently stalled by waitrequest stays asserted until accepted, as Avalon requires.
- In DRAIN, returning data is discarded, not pushed. When outstanding==0 (and no read is pending), the block goes to IDLE and the FIFO is flushed.
- stop in IDLE is ignored. start while in RUN or DRAIN is ignored.
- stop and start asserted together: stop wins.

Other rules:
- A direction change mid-stream applies from the next address step. Words already in the FIFO are kept.
- Counter widths: fifo_count is $clog2(FIFO_DEPTH)+1 bits and outstanding is $clog2(MAX_OUTSTANDING)+1 bits, so neither saturates.

Decomposition:
- Package flash_stream_pkg: state enum (IDLE, RUN, DRAIN) and the direction constants DIR_FWD and DIR_REV.
- Sub-module sync_fifo:
  - Parameters: DATA_W, DEPTH.
  - Inputs: push, pop, flush.
  - Outputs: rdata, count, empty, full. The read is registered.
- Instantiate sync_fifo once for the prefetch buffer.

Test Plan:
- Forward wrap: start_addr=0x10, end_addr=0x12, direction=0, waitrequest=0, 1-cycle-latency memory model → accepted addresses 0x10, 0x11, 0x12, 0x10, …; FIFO fills to 4 and reads stop while no sample_req arrives.
- Reverse: start_addr=0x10, end_addr=0x12, direction=1 → addresses 0x12, 0x11, 0x10, 0x12; sample_req pops return data in that same order.
- Waitrequest stall: hold waitrequest=1 for 3 cycles on address 0x11 → read and address stay stable those 3 cycles; exactly one acceptance; no address skipped.
- Underrun: sample_req on the cycle after start (FIFO empty) → underrun=1 for one cycle, sample_valid=0, sample_data=0.
- Stop with 2 outstanding (memory latency 5) → flash_mem_read=0 next cycle; busy stays 1 until both returns; FIFO count is 0 afterwards; returned data is not visible on sample_data.
- Reset mid-RUN with reads outstanding → all outputs at reset values next cycle; late readdatavalid is ignored; a subsequent start begins cleanly at start_addr.
